apple_text_line_fetch: RTL

Text-mode scanline fetcher that sits directly downstream of the Apple II shadow-memory block. Per text row it computes the Apple II interleaved text base address, streams the 20 text-RAM words covering columns 0–39 through the video read port, and unpacks main/aux bytes into an 80-character line buffer in 80-column display order. A ping-pong buffer lets the character renderer read one row while the next is fetched.

---
 rtl/apple_video_pkg.sv | 28 ++
 rtl/apple_text_line_fetch_if.sv | 41 ++++
 rtl/text_line_buffer.sv | 49 ++++
 rtl/apple_text_line_fetch.sv | 102 ++++++++++
 4 files changed

// File: rtl/apple_video_pkg.sv
// rtl/apple_video_pkg.sv - shared types, constants and base-address helper for the text line fetcher
package apple_video_pkg;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        DRAIN,
        DONE
    } fetch_state_t;

    localparam logic [4:0]  TEXT_ROWS       = 5'd24;
    localparam logic [4:0]  TEXT_WORDS      = 5'd20;
    localparam logic [6:0]  TEXT_COLS       = 7'd80;
    localparam logic [15:0] TEXT_PAGE1_BASE = 16'h0400;
    localparam logic [15:0] TEXT_PAGE2_BASE = 16'h0800;

    // Apple II interleave: row[2:0] strides by 128 bytes, row[4:3] selects a 40-byte third.
    function automatic logic [15:0] text_row_base(input logic [4:0] row, input logic page2);
        logic [15:0] page;
        logic [15:0] low_part;
        logic [15:0] third_part;
        page       = page2 ? TEXT_PAGE2_BASE : TEXT_PAGE1_BASE;
        low_part   = {6'd0, row[2:0], 7'd0};
        third_part = {14'd0, row[4:3]} * 16'd40;
        return page + low_part + third_part;
    endfunction

endpackage

// File: rtl/apple_text_line_fetch_if.sv
// rtl/apple_text_line_fetch_if.sv - request, video read port and renderer port bundle
interface apple_text_line_fetch_if;

    logic        start_i;
    logic [4:0]  row_i;
    logic        page2_i;
    logic        busy_o;
    logic        done_o;
    logic [15:0] video_address_o;
    logic        video_rd_o;
    logic [31:0] video_data_i;
    logic [6:0]  char_col_i;
    logic [7:0]  char_o;

    modport slave (
        input  start_i,
        input  row_i,
        input  page2_i,
        input  video_data_i,
        input  char_col_i,
        output busy_o,
        output done_o,
        output video_address_o,
        output video_rd_o,
        output char_o
    );

    modport master (
        output start_i,
        output row_i,
        output page2_i,
        output video_data_i,
        output char_col_i,
        input  busy_o,
        input  done_o,
        input  video_address_o,
        input  video_rd_o,
        input  char_o
    );

endinterface

// File: rtl/text_line_buffer.sv
// rtl/text_line_buffer.sv - two 20-word line buffers, word write, registered byte read
module text_line_buffer
    import apple_video_pkg::*;
(
    input  logic        clk,
    input  logic        resetn,
    input  logic        wr_en,
    input  logic        wr_sel,
    input  logic [4:0]  wr_idx,
    input  logic [31:0] wr_data,
    input  logic        rd_sel,
    input  logic [6:0]  rd_col,
    output logic [7:0]  rd_char
);

    // Byte lane n of a word holds display column 4*idx+n.
    logic [31:0] mem [0:1][0:TEXT_WORDS-1];
    logic [31:0] rd_word;
    logic [7:0]  rd_byte;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_sel][wr_idx] <= wr_data;
        end
    end

    always_comb begin
        rd_word = '0;
        rd_byte = 8'h00;
        if (rd_col < TEXT_COLS) begin
            rd_word = mem[rd_sel][rd_col[6:2]];
            case (rd_col[1:0])
                2'd0:    rd_byte = rd_word[7:0];
                2'd1:    rd_byte = rd_word[15:8];
                2'd2:    rd_byte = rd_word[23:16];
                default: rd_byte = rd_word[31:24];
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            rd_char <= 8'h00;
        end else begin
            rd_char <= rd_byte;
        end
    end

endmodule

// File: rtl/apple_text_line_fetch.sv
// rtl/apple_text_line_fetch.sv - per-row text RAM fetch into a ping-pong 80-column line buffer
module apple_text_line_fetch
    import apple_video_pkg::*;
#(
    parameter bit DOUBLE_BUFFER = 1'b1
) (
    input logic                    clk_logic,
    input logic                    system_reset_n,
    apple_text_line_fetch_if.slave vid
);

    fetch_state_t state_q, state_d;
    logic [15:0]  addr_q, addr_d;
    logic [4:0]   k_q, k_d;
    logic         disp_sel_q, disp_sel_d;
    logic         cap_valid_q;
    logic [4:0]   cap_k_q;
    logic [31:0]  fill_word;
    logic         fill_sel;

    always_ff @(posedge clk_logic) begin
        if (!system_reset_n) begin
            state_q     <= IDLE;
            addr_q      <= TEXT_PAGE1_BASE;
            k_q         <= '0;
            disp_sel_q  <= 1'b0;
            cap_valid_q <= 1'b0;
            cap_k_q     <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            k_q         <= k_d;
            disp_sel_q  <= disp_sel_d;
            cap_valid_q <= (state_q == FETCH);
            cap_k_q     <= k_q;
        end
    end

    // The address is held after the last word so the port mux stays inside text RAM.
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        k_d        = k_q;
        disp_sel_d = disp_sel_q;
        case (state_q)
            IDLE: begin
                if (vid.start_i) begin
                    if (vid.row_i < TEXT_ROWS) begin
                        addr_d  = text_row_base(vid.row_i, vid.page2_i);
                        k_d     = '0;
                        state_d = FETCH;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            FETCH: begin
                if (k_q == TEXT_WORDS - 5'd1) begin
                    state_d = DRAIN;
                end else begin
                    k_d    = k_q + 5'd1;
                    addr_d = addr_q + 16'd2;
                end
            end
            DRAIN: begin
                state_d = DONE;
                if (DOUBLE_BUFFER) begin
                    disp_sel_d = ~disp_sel_q;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign vid.busy_o          = (state_q == FETCH) || (state_q == DRAIN);
    assign vid.done_o          = (state_q == DONE);
    assign vid.video_rd_o      = (state_q == FETCH);
    assign vid.video_address_o = addr_q;

    // Port bytes are main-even, aux-even, main-odd, aux-odd; 80-column order puts aux first.
    assign fill_word = {vid.video_data_i[23:16], vid.video_data_i[31:24],
                        vid.video_data_i[7:0],   vid.video_data_i[15:8]};
    assign fill_sel  = DOUBLE_BUFFER ? ~disp_sel_q : disp_sel_q;

    text_line_buffer u_line_buffer (
        .clk     (clk_logic),
        .resetn  (system_reset_n),
        .wr_en   (cap_valid_q),
        .wr_sel  (fill_sel),
        .wr_idx  (cap_k_q),
        .wr_data (fill_word),
        .rd_sel  (disp_sel_q),
        .rd_col  (vid.char_col_i),
        .rd_char (vid.char_o)
    );

endmodule
